meas_mem_seq: RTL and testbench

- Sequencer for the measurement word buffer (mem, default 8-bit × 1024). It owns every buffer port.
- Capture: accepts C_NUM_WORDS response words from the PUF sampler through a valid/ready handshake and writes them to consecutive addresses.
- Readout: streams the stored words, lowest address first, to the host link through a second valid/ready handshake.
- Sits between the sampler, the buffer and the host interface. Only one phase is active at a time, so the buffer is time-shared between its two users.

---
 rtl/meas_pkg.sv | 20 ++
 rtl/meas_mem_seq.sv | 158 +++++++++++++++
 tb/tb_meas_mem_seq.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_pkg.sv
// Shared constants for the measurement buffer path: default widths used by
// the buffer, the host interface and the sequencer, plus the sequencer's
// 3-bit state encoding.
package meas_pkg;

  localparam int unsigned C_WORDSIZE_DEF  = 8;
  localparam int unsigned C_ADDRSIZE_DEF  = 10;
  localparam int unsigned C_NUM_WORDS_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAP_WAIT = 3'd1,
    ST_WR_HI    = 3'd2,
    ST_WR_LO    = 3'd3,
    ST_RD_SET   = 3'd4,
    ST_RD_OUT   = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/meas_mem_seq.sv
// Measurement buffer sequencer. Captures C_NUM_WORDS sampler words into the
// buffer at consecutive addresses, or streams them back out to the host,
// one phase at a time so the buffer ports are time-shared.
// Ports:
//   I_clk, I_rst                      clock, synchronous active-high reset
//   I_start_cap, I_start_rd, I_abort  phase control
//   I_in_data/I_in_valid/O_in_ready   sampler handshake
//   O_out_data/O_out_valid/I_out_ready host handshake
//   O_mem_addr/O_mem_data/O_mem_wrclk buffer write port (commit on wrclk fall)
//   I_mem_rdata                       buffer read data (combinational on addr)
//   O_busy, O_done, O_count           status
module meas_mem_seq
  import meas_pkg::*;
#(
  parameter int unsigned C_WORDSIZE  = C_WORDSIZE_DEF,
  parameter int unsigned C_ADDRSIZE  = C_ADDRSIZE_DEF,
  parameter int unsigned C_NUM_WORDS = C_NUM_WORDS_DEF
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_start_cap,
  input  logic                  I_start_rd,
  input  logic                  I_abort,
  input  logic [C_WORDSIZE-1:0] I_in_data,
  input  logic                  I_in_valid,
  output logic                  O_in_ready,
  output logic [C_WORDSIZE-1:0] O_out_data,
  output logic                  O_out_valid,
  input  logic                  I_out_ready,
  output logic [C_ADDRSIZE-1:0] O_mem_addr,
  output logic [C_WORDSIZE-1:0] O_mem_data,
  output logic                  O_mem_wrclk,
  input  logic [C_WORDSIZE-1:0] I_mem_rdata,
  output logic                  O_busy,
  output logic                  O_done,
  output logic [C_ADDRSIZE:0]   O_count
);

  // One extra counter bit so a full 2^C_ADDRSIZE phase ends without wrapping.
  localparam int unsigned     CW   = C_ADDRSIZE + 1;
  localparam logic [CW-1:0]   LAST = CW'(C_NUM_WORDS);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [C_ADDRSIZE-1:0]   addr_q, addr_d;
  logic [C_WORDSIZE-1:0]   wdata_q, wdata_d;
  logic [C_WORDSIZE-1:0]   odata_q, odata_d;
  logic                    wrclk_q, wrclk_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // State and all registered outputs.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      odata_q     <= '0;
      wrclk_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      odata_q     <= odata_d;
      wrclk_q     <= wrclk_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state, counter and address/data; flags follow the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    odata_d = odata_q;

    if (I_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (I_start_cap) begin
            state_d = ST_CAP_WAIT;
            cnt_d   = '0;
            addr_d  = '0;
          end else if (I_start_rd) begin
            state_d = ST_RD_SET;
            cnt_d   = '0;
            addr_d  = '0;
          end
        end
        ST_CAP_WAIT: begin
          if (I_in_valid && in_ready_q) begin
            wdata_d = I_in_data;
            state_d = ST_WR_HI;
          end
        end
        ST_WR_HI: state_d = ST_WR_LO;
        // Address is only advanced when another word follows, so it holds in DONE.
        ST_WR_LO: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CAP_WAIT;
            addr_d  = cnt_d[C_ADDRSIZE-1:0];
          end
        end
        // Read data has settled for a full cycle on the held address.
        ST_RD_SET: begin
          state_d = ST_RD_OUT;
          odata_d = I_mem_rdata;
        end
        ST_RD_OUT: begin
          if (I_out_ready) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RD_SET;
              addr_d  = cnt_d[C_ADDRSIZE-1:0];
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    wrclk_d     = (state_d == ST_WR_HI);
    in_ready_d  = (state_d == ST_CAP_WAIT);
    out_valid_d = (state_d == ST_RD_OUT);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
  end

  assign O_in_ready  = in_ready_q;
  assign O_out_data  = odata_q;
  assign O_out_valid = out_valid_q;
  assign O_mem_addr  = addr_q;
  assign O_mem_data  = wdata_q;
  assign O_mem_wrclk = wrclk_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;
  assign O_count     = cnt_q;

endmodule

// File: tb/tb_meas_mem_seq.sv
// Bench for meas_mem_seq: two instances (1024-deep buffer with 4-word phases,
// and an 8-deep buffer with full-depth phases), each with its own buffer array
// written on the falling edge of the write strobe.
module tb_meas_mem_seq;

  localparam int unsigned AA = 10;
  localparam int unsigned NA = 4;
  localparam int unsigned AB = 3;
  localparam int unsigned NB = 8;

  logic clk;
  logic rst;

  // Instance A signals
  logic          sc_a, sr_a, ab_a, iv_a, ir_a, ov_a, ordy_a, wrclk_a, busy_a, done_a;
  logic [7:0]    idata_a, odata_a, wdata_a, rdata_a;
  logic [AA-1:0] addr_a;
  logic [AA:0]   count_a;

  // Instance B signals
  logic          sc_b, sr_b, ab_b, iv_b, ir_b, ov_b, ordy_b, wrclk_b, busy_b, done_b;
  logic [7:0]    idata_b, odata_b, wdata_b, rdata_b;
  logic [AB-1:0] addr_b;
  logic [AB:0]   count_b;

  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:7];

  int tests = 0;
  int fails = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  int wr0_cnt_b = 0;

  logic [7:0] src_q[$];
  logic [7:0] got_q[$];

  meas_mem_seq #(.C_WORDSIZE(8), .C_ADDRSIZE(AA), .C_NUM_WORDS(NA)) dut_a (
    .I_clk(clk), .I_rst(rst), .I_start_cap(sc_a), .I_start_rd(sr_a), .I_abort(ab_a),
    .I_in_data(idata_a), .I_in_valid(iv_a), .O_in_ready(ir_a),
    .O_out_data(odata_a), .O_out_valid(ov_a), .I_out_ready(ordy_a),
    .O_mem_addr(addr_a), .O_mem_data(wdata_a), .O_mem_wrclk(wrclk_a),
    .I_mem_rdata(rdata_a), .O_busy(busy_a), .O_done(done_a), .O_count(count_a)
  );

  meas_mem_seq #(.C_WORDSIZE(8), .C_ADDRSIZE(AB), .C_NUM_WORDS(NB)) dut_b (
    .I_clk(clk), .I_rst(rst), .I_start_cap(sc_b), .I_start_rd(sr_b), .I_abort(ab_b),
    .I_in_data(idata_b), .I_in_valid(iv_b), .O_in_ready(ir_b),
    .O_out_data(odata_b), .O_out_valid(ov_b), .I_out_ready(ordy_b),
    .O_mem_addr(addr_b), .O_mem_data(wdata_b), .O_mem_wrclk(wrclk_b),
    .I_mem_rdata(rdata_b), .O_busy(busy_b), .O_done(done_b), .O_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffers: commit on the falling edge of the write strobe.
  always @(negedge wrclk_a) if (!rst) begin
    mem_a[addr_a] <= wdata_a;
    wr_cnt_a++;
  end
  assign rdata_a = mem_a[addr_a];

  always @(negedge wrclk_b) if (!rst) begin
    mem_b[addr_b] <= wdata_b;
    wr_cnt_b++;
    if (addr_b == '0) wr0_cnt_b++;
  end
  assign rdata_b = mem_b[addr_b];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Reference model for instance A. Phase-level view: idle/done, capture
  // with a 2-cycle write gap after each accepted word, readout with a 1-cycle
  // address setup before each word. Inputs seen on the previous falling edge
  // are applied as the effect of the rising edge just passed.
  // ---------------------------------------------------------------------
  localparam int PH_IDLE = 0, PH_CAP = 1, PH_RD = 2, PH_DONE = 3;
  int         phase = PH_IDLE;
  int         gap = 0;
  int         mcount = 0;
  logic [7:0] model_mem [0:1023];
  logic       p_rst = 1'b1, p_ab = 1'b0, p_sc = 1'b0, p_sr = 1'b0;
  logic       p_iv = 1'b0, p_ir = 1'b0, p_ordy = 1'b0;
  logic [7:0] p_id = 8'h00;

  always @(negedge clk) begin
    if (p_rst) begin
      phase = PH_IDLE; gap = 0; mcount = 0;
    end else if (p_ab) begin
      phase = PH_IDLE;
    end else begin
      case (phase)
        PH_IDLE, PH_DONE: begin
          if (p_sc) begin
            phase = PH_CAP; gap = 0; mcount = 0;
          end else if (p_sr) begin
            phase = PH_RD; gap = 1; mcount = 0;
          end
        end
        PH_CAP: begin
          if (gap > 0) begin
            gap--;
            if (gap == 0) begin
              mcount++;
              if (mcount == NA) phase = PH_DONE;
            end
          end else if (p_iv && p_ir) begin
            model_mem[mcount % 1024] = p_id;
            gap = 2;
          end
        end
        PH_RD: begin
          if (gap > 0) gap--;
          else if (p_ordy) begin
            mcount++;
            if (mcount == NA) phase = PH_DONE;
            else gap = 1;
          end
        end
        default: phase = PH_IDLE;
      endcase
    end

    chk("in_ready",  32'(ir_a),    32'(phase == PH_CAP && gap == 0));
    chk("wrclk",     32'(wrclk_a), 32'(phase == PH_CAP && gap == 2));
    chk("out_valid", 32'(ov_a),    32'(phase == PH_RD && gap == 0));
    chk("busy",      32'(busy_a),  32'(phase == PH_CAP || phase == PH_RD));
    chk("done",      32'(done_a),  32'(phase == PH_DONE));
    chk("count",     32'(count_a), 32'(mcount));
    if (phase == PH_CAP || phase == PH_RD) chk("addr", 32'(addr_a), 32'(mcount % 1024));
    if (phase == PH_CAP && gap > 0) chk("wdata", 32'(wdata_a), 32'(model_mem[mcount % 1024]));
    if (phase == PH_RD && gap == 0) chk("out_data", 32'(odata_a), 32'(model_mem[mcount % 1024]));

    p_rst = rst; p_ab = ab_a; p_sc = sc_a; p_sr = sr_a;
    p_iv = iv_a; p_ir = ir_a; p_ordy = ordy_a; p_id = idata_a;
  end

  // Sampler for A: valid held, next word presented after each handshake.
  task automatic send_a();
    int t;
    iv_a = 1'b1;
    while (src_q.size() > 0) begin
      idata_a = src_q[0];
      t = 0;
      while (!ir_a && t < 50) begin tick(); t++; end
      if (t >= 50) begin
        tests++; fails++;
        $display("FAIL send_a: in_ready timeout, got 0 expected 1");
        src_q.delete();
      end else begin
        tick();
        void'(src_q.pop_front());
      end
    end
    iv_a = 1'b0;
  endtask

  task automatic send_b();
    int t;
    iv_b = 1'b1;
    while (src_q.size() > 0) begin
      idata_b = src_q[0];
      t = 0;
      while (!ir_b && t < 50) begin tick(); t++; end
      if (t >= 50) begin
        tests++; fails++;
        $display("FAIL send_b: in_ready timeout, got 0 expected 1");
        src_q.delete();
      end else begin
        tick();
        void'(src_q.pop_front());
      end
    end
    iv_b = 1'b0;
  endtask

  // Host for A: pat 0 = always ready, pat 1 = ready one cycle in three.
  task automatic read_a(input int pat);
    int t;
    t = 0;
    got_q.delete();
    while (!done_a && t < 200) begin
      ordy_a = (pat == 0) ? 1'b1 : ((t % 3) == 0);
      if (ov_a && ordy_a) got_q.push_back(odata_a);
      tick();
      t++;
    end
    ordy_a = 1'b0;
    chk("read_a_terminates", 32'(t < 200), 32'd1);
  endtask

  task automatic chk_seq(input string name);
    logic [7:0] exp_w [4];
    exp_w[0] = 8'hA1; exp_w[1] = 8'hB2; exp_w[2] = 8'hC3; exp_w[3] = 8'hD4;
    chk({name, "_len"}, 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk(name, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_w[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int w0;
    rst = 1'b1;
    {sc_a, sr_a, ab_a, iv_a, ordy_a} = '0;
    {sc_b, sr_b, ab_b, iv_b} = '0;
    ordy_b  = 1'b1;
    idata_a = 8'h00;
    idata_b = 8'h00;
    repeat (3) tick();

    // Reset values
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_ready", 32'(ir_a),    32'd0);
    chk("rst_valid", 32'(ov_a),    32'd0);
    chk("rst_wrclk", 32'(wrclk_a), 32'd0);
    chk("rst_addr",  32'(addr_a),  32'd0);
    rst = 1'b0;
    tick();

    // 1: capture A1..D4, 13 cycles from start to DONE
    w0 = wr_cnt_a;
    src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    sc_a = 1'b1;
    n = 0;
    fork
      send_a();
      begin
        tick(); sc_a = 1'b0; n = 1;
        while (!done_a && n < 100) begin tick(); n++; end
      end
    join
    chk("t1_cycles", 32'(n), 32'd13);
    chk("t1_mem0", 32'(mem_a[0]), 32'hA1);
    chk("t1_mem1", 32'(mem_a[1]), 32'hB2);
    chk("t1_mem2", 32'(mem_a[2]), 32'hC3);
    chk("t1_mem3", 32'(mem_a[3]), 32'hD4);
    chk("t1_wrpulses", 32'(wr_cnt_a - w0), 32'd4);
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_count", 32'(count_a), 32'd4);

    // 2: readout, host always ready
    sr_a = 1'b1; tick(); sr_a = 1'b0;
    read_a(0);
    chk_seq("t2_word");
    chk("t2_done", 32'(done_a), 32'd1);
    chk("t2_count", 32'(count_a), 32'd4);

    // 3: readout with host ready one cycle in three
    sr_a = 1'b1; tick(); sr_a = 1'b0;
    read_a(1);
    chk_seq("t3_word");
    chk("t3_count", 32'(count_a), 32'd4);

    // 4: abort in WR_HI of word 2
    src_q = '{8'h11, 8'h22, 8'hC3};
    sc_a = 1'b1; tick(); sc_a = 1'b0;
    fork
      send_a();
      begin
        n = 0;
        while (!(wrclk_a && addr_a == 10'd2) && n < 100) begin tick(); n++; end
        ab_a = 1'b1; tick(); ab_a = 1'b0;
      end
    join
    chk("t4_reached_wr_hi", 32'(n < 100), 32'd1);
    chk("t4_busy",  32'(busy_a),  32'd0);
    chk("t4_wrclk", 32'(wrclk_a), 32'd0);
    chk("t4_ready", 32'(ir_a),    32'd0);
    chk("t4_count", 32'(count_a), 32'd2);
    chk("t4_mem2",  32'(mem_a[2]), 32'hC3);
    chk("t4_mem1",  32'(mem_a[1]), 32'h22);

    // 5: both starts together, capture wins
    sc_a = 1'b1; sr_a = 1'b1; tick(); sc_a = 1'b0; sr_a = 1'b0;
    chk("t5_ready", 32'(ir_a), 32'd1);
    chk("t5_valid", 32'(ov_a), 32'd0);
    chk("t5_count", 32'(count_a), 32'd0);
    ab_a = 1'b1; tick(); ab_a = 1'b0;
    chk("t5_abort_busy", 32'(busy_a), 32'd0);

    // Reset in the middle of a capture
    sc_a = 1'b1; tick(); sc_a = 1'b0;
    idata_a = 8'h5A; iv_a = 1'b1; tick(); tick(); iv_a = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_count", 32'(count_a), 32'd0);
    chk("rst_mid_wrclk", 32'(wrclk_a), 32'd0);
    chk("rst_mid_busy",  32'(busy_a),  32'd0);
    tick();

    // 6: 8-deep buffer, full capture of 0..7
    for (int i = 0; i < 8; i++) src_q.push_back(8'(i));
    sc_b = 1'b1; tick(); sc_b = 1'b0;
    send_b();
    n = 0;
    while (!done_b && n < 20) begin tick(); n++; end
    repeat (5) tick();
    chk("t6_done",    32'(done_b),   32'd1);
    chk("t6_count",   32'(count_b),  32'd8);
    chk("t6_addr",    32'(addr_b),   32'd7);
    chk("t6_mem7",    32'(mem_b[7]), 32'd7);
    chk("t6_mem0",    32'(mem_b[0]), 32'd0);
    chk("t6_mem4",    32'(mem_b[4]), 32'd4);
    chk("t6_writes",  32'(wr_cnt_b), 32'd8);
    chk("t6_writes0", 32'(wr0_cnt_b), 32'd1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
